fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_if.sv | 53 +++++
 rtl/fifo_wr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the four-requester write port and the FIFO write port of the
//   round-robin FIFO write arbiter.
//
//   Signals:
//     req        [3:0]         per-requester "word presented" flag
//     req_data   [4*DSIZE-1:0] requester i word on [i*DSIZE +: DSIZE]
//     ack        [3:0]         one-hot pulse, word of requester i written
//     wfull                    FIFO full flag (write domain)
//     winc                     FIFO write enable
//     wdata      [DSIZE-1:0]   FIFO write data
//     gnt        [3:0]         one-hot current owner, zero when idle
//     burst_cnt  [3:0]         words written in the current grant
//
//   Modports:
//     master : requesters + FIFO side (drives req, req_data, wfull)
//     slave  : arbiter side (drives ack, winc, wdata, gnt, burst_cnt)
// ----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int DSIZE = 8
);
  logic [3:0]         req;
  logic [4*DSIZE-1:0] req_data;
  logic [3:0]         ack;
  logic               wfull;
  logic               winc;
  logic [DSIZE-1:0]   wdata;
  logic [3:0]         gnt;
  logic [3:0]         burst_cnt;

  modport master (
    output req,
    output req_data,
    output wfull,
    input  ack,
    input  winc,
    input  wdata,
    input  gnt,
    input  burst_cnt
  );

  modport slave (
    input  req,
    input  req_data,
    input  wfull,
    output ack,
    output winc,
    output wdata,
    output gnt,
    output burst_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that lets one of four requesters write a burst of up
//   to MAX_BURST words into an asynchronous FIFO's write port.
//
//   Ports:
//     wclk    write-domain clock, all state on the rising edge
//     wrst_n  asynchronous active-low reset
//     bus     fifo_wr_arbiter_if.slave (req/req_data/wfull in,
//             ack/winc/wdata/gnt/burst_cnt out)
//
//   Behaviour summary:
//     IDLE  : nothing granted; any request at a rising edge grants the first
//             requester found searching upward from (last+1) mod 4.
//     GRANT : the owner writes one word per cycle while it requests and the
//             FIFO is not full. The grant drops when the owner stops
//             requesting or when its MAX_BURST-th word is written; a release
//             always leaves exactly one IDLE cycle before the next grant.
// ----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  fifo_wr_arbiter_if.slave         bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // burst_cnt value at which the next write is the last one of the burst
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       gnt_r;
  logic [3:0]       gnt_nxt_s;
  logic [1:0]       last_r;
  logic [1:0]       last_nxt_s;
  logic [3:0]       burst_cnt_r;
  logic [3:0]       burst_cnt_nxt_s;

  logic [1:0]       owner_idx_s;
  logic             owner_req_s;
  logic [1:0]       winner_idx_s;
  logic             release_s;
  logic             winc_s;
  logic [3:0]       ack_s;
  logic [DSIZE-1:0] wdata_s;

  // First set bit of r searching upward from (last+1) mod 4, wrapping.
  function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last + 2'd1;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = last + 2'd1 + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Owner index decoded from the registered one-hot grant.
  always_comb begin
    owner_idx_s = 2'd0;
    case (gnt_r)
      4'b0001: owner_idx_s = 2'd0;
      4'b0010: owner_idx_s = 2'd1;
      4'b0100: owner_idx_s = 2'd2;
      4'b1000: owner_idx_s = 2'd3;
      default: owner_idx_s = 2'd0;
    endcase
  end

  // gnt_r is one-hot or zero, so masking req with it yields the owner's
  // request and is automatically 0 while idle.
  assign owner_req_s  = |(bus.req & gnt_r);
  assign winner_idx_s = rr_pick(bus.req, last_r);
  assign winc_s       = (state_r == GRANT) & owner_req_s & ~bus.wfull;
  assign release_s    = (state_r == GRANT) &
                        (~owner_req_s | (winc_s & (burst_cnt_r == LAST_BEAT)));

  // State and grant bookkeeping registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r     <= IDLE;
      gnt_r       <= 4'd0;
      last_r      <= 2'd3;
      burst_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      gnt_r       <= gnt_nxt_s;
      last_r      <= last_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end

  // Next-state logic: arbitration in IDLE, burst counting / release in GRANT.
  always_comb begin
    state_nxt_s     = state_r;
    gnt_nxt_s       = gnt_r;
    last_nxt_s      = last_r;
    burst_cnt_nxt_s = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          state_nxt_s     = GRANT;
          gnt_nxt_s       = 4'd1 << winner_idx_s;
          last_nxt_s      = winner_idx_s;
          burst_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s     = IDLE;
          gnt_nxt_s       = 4'd0;
          burst_cnt_nxt_s = 4'd0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_nxt_s     = IDLE;
          gnt_nxt_s       = 4'd0;
          burst_cnt_nxt_s = 4'd0;
        end else if (winc_s) begin
          burst_cnt_nxt_s = burst_cnt_r + 4'd1;
        end else begin
          // wfull stall: grant and count hold, no timeout
          burst_cnt_nxt_s = burst_cnt_r;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        gnt_nxt_s       = 4'd0;
        burst_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Write-port outputs, combinational from the registered grant so a reset
  // clears them without waiting for a clock.
  always_comb begin
    ack_s   = 4'd0;
    wdata_s = {DSIZE{1'b0}};
    if (gnt_r != 4'd0) begin
      wdata_s = bus.req_data[owner_idx_s*DSIZE +: DSIZE];
      ack_s   = winc_s ? gnt_r : 4'd0;
    end else begin
      wdata_s = {DSIZE{1'b0}};
      ack_s   = 4'd0;
    end
  end

  assign bus.winc      = winc_s;
  assign bus.ack       = ack_s;
  assign bus.wdata     = wdata_s;
  assign bus.gnt       = gnt_r;
  assign bus.burst_cnt = burst_cnt_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (DSIZE=8, MAX_BURST=4): a vector
//   table for the basic single-requester burst, hand sequences for
//   round-robin order, full stall, early release and mid-burst reset, then
//   random traffic checked against a behavioural model.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  logic wclk;
  logic wrst_n;

  fifo_wr_arbiter_if #(.DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(.DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_pass;
  int n_total;

  // behavioural model state (owner = -1 when idle)
  int m_owner;
  int m_cnt;
  int m_last;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        wfull;
    logic [3:0]  e_gnt;
    logic        e_winc;
    logic [7:0]  e_wdata;
    logic [3:0]  e_ack;
    logic [3:0]  e_bcnt;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs (just after a rising edge), check outputs on the falling
  // edge, then advance through the next rising edge.
  task automatic apply(input logic [3:0] r, input logic [31:0] d, input logic wf,
                       input logic [3:0] eg, input logic ew, input logic [7:0] ed,
                       input logic [3:0] ea, input logic [3:0] eb, input string tag);
    bus.req      = r;
    bus.req_data = d;
    bus.wfull    = wf;
    @(negedge wclk);
    chk({tag, ".gnt"},       32'(bus.gnt),       32'(eg));
    chk({tag, ".winc"},      32'(bus.winc),      32'(ew));
    chk({tag, ".wdata"},     32'(bus.wdata),     32'(ed));
    chk({tag, ".ack"},       32'(bus.ack),       32'(ea));
    chk({tag, ".burst_cnt"}, 32'(bus.burst_cnt), 32'(eb));
    chk({tag, ".winc_full"}, 32'(bus.winc & wf), 32'd0);
    @(posedge wclk);
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 3;
  endtask

  task automatic do_reset();
    bus.req      = 4'd0;
    bus.req_data = 32'd0;
    bus.wfull    = 1'b0;
    wrst_n       = 1'b0;
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    model_reset();
  endtask

  logic [31:0] dw;
  logic [3:0]  rq;
  logic        wf;
  logic [31:0] rd;
  logic [5:0]  seq [4];
  logic [3:0]  eg;
  logic        ew;
  logic [7:0]  ed;
  logic [3:0]  ea;
  logic [3:0]  eb;
  int          pick;

  initial begin
    n_pass       = 0;
    n_total      = 0;
    wrst_n       = 1'b0;
    bus.req      = 4'd0;
    bus.req_data = 32'd0;
    bus.wfull    = 1'b0;
    dw           = 32'hD4C3B2A5;
    model_reset();

    // --- reset state -------------------------------------------------------
    #2;
    chk("reset.gnt",       32'(bus.gnt),       32'd0);
    chk("reset.winc",      32'(bus.winc),      32'd0);
    chk("reset.burst_cnt", 32'(bus.burst_cnt), 32'd0);

    // --- vector table: single requester burst and re-grant -------------------
    tbl[0] = '{4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 4'd0};
    tbl[1] = '{4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0001, 1'b1, 8'hA5, 4'b0001, 4'd0};
    tbl[2] = '{4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0001, 1'b1, 8'hA5, 4'b0001, 4'd1};
    tbl[3] = '{4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0001, 1'b1, 8'hA5, 4'b0001, 4'd2};
    tbl[4] = '{4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0001, 1'b1, 8'hA5, 4'b0001, 4'd3};
    tbl[5] = '{4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 4'd0};
    tbl[6] = '{4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0001, 1'b1, 8'hA5, 4'b0001, 4'd0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].req, tbl[i].data, tbl[i].wfull, tbl[i].e_gnt, tbl[i].e_winc,
            tbl[i].e_wdata, tbl[i].e_ack, tbl[i].e_bcnt, $sformatf("tbl%0d", i));
    end

    // --- round robin with all requesting: 0,1,2,3,0 -------------------------
    do_reset();
    for (int g = 0; g < 5; g++) begin
      apply(4'b1111, dw, 1'b0, 4'd0, 1'b0, 8'h00, 4'd0, 4'd0, "rr_idle");
      for (int k = 0; k < 4; k++) begin
        apply(4'b1111, dw, 1'b0, 4'(1 << (g % 4)), 1'b1, dw[(g % 4)*8 +: 8],
              4'(1 << (g % 4)), 4'(k), $sformatf("rr_g%0d_w%0d", g, k));
      end
    end

    // --- owner 1 stalled by wfull at burst_cnt=2 ----------------------------
    do_reset();
    apply(4'b0010, dw, 1'b0, 4'd0,    1'b0, 8'h00, 4'd0,    4'd0, "stall_idle");
    apply(4'b0010, dw, 1'b0, 4'b0010, 1'b1, 8'hB2, 4'b0010, 4'd0, "stall_w0");
    apply(4'b0010, dw, 1'b0, 4'b0010, 1'b1, 8'hB2, 4'b0010, 4'd1, "stall_w1");
    for (int k = 0; k < 5; k++) begin
      apply(4'b0010, dw, 1'b1, 4'b0010, 1'b0, 8'hB2, 4'd0, 4'd2, "stall_full");
    end
    apply(4'b0010, dw, 1'b0, 4'b0010, 1'b1, 8'hB2, 4'b0010, 4'd2, "stall_w2");
    apply(4'b0010, dw, 1'b0, 4'b0010, 1'b1, 8'hB2, 4'b0010, 4'd3, "stall_w3");
    apply(4'b0010, dw, 1'b0, 4'd0,    1'b0, 8'h00, 4'd0,    4'd0, "stall_rel");

    // --- owner 2 drops after one word, next grant wraps to 0 ----------------
    do_reset();
    apply(4'b0100, dw, 1'b0, 4'd0,    1'b0, 8'h00, 4'd0,    4'd0, "drop_idle");
    apply(4'b0101, dw, 1'b0, 4'b0100, 1'b1, 8'hC3, 4'b0100, 4'd0, "drop_w0");
    apply(4'b0001, dw, 1'b0, 4'b0100, 1'b0, 8'hC3, 4'd0,    4'd1, "drop_rel");
    apply(4'b0001, dw, 1'b0, 4'd0,    1'b0, 8'h00, 4'd0,    4'd0, "drop_gap");
    apply(4'b0001, dw, 1'b0, 4'b0001, 1'b1, 8'hA5, 4'b0001, 4'd0, "drop_wrap");

    // --- drop request while stalled: release with no word written -----------
    do_reset();
    apply(4'b1000, dw, 1'b0, 4'd0,    1'b0, 8'h00, 4'd0, 4'd0, "sdrop_idle");
    apply(4'b1000, dw, 1'b1, 4'b1000, 1'b0, 8'hD4, 4'd0, 4'd0, "sdrop_full");
    apply(4'b0000, dw, 1'b1, 4'b1000, 1'b0, 8'hD4, 4'd0, 4'd0, "sdrop_rel");
    apply(4'b0000, dw, 1'b0, 4'd0,    1'b0, 8'h00, 4'd0, 4'd0, "sdrop_done");

    // --- asynchronous reset during owner-3 burst ----------------------------
    do_reset();
    apply(4'b1000, dw, 1'b0, 4'd0,    1'b0, 8'h00, 4'd0,    4'd0, "arst_idle");
    apply(4'b1000, dw, 1'b0, 4'b1000, 1'b1, 8'hD4, 4'b1000, 4'd0, "arst_w0");
    apply(4'b1000, dw, 1'b0, 4'b1000, 1'b1, 8'hD4, 4'b1000, 4'd1, "arst_w1");
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst.gnt",       32'(bus.gnt),       32'd0);
    chk("arst.winc",      32'(bus.winc),      32'd0);
    chk("arst.ack",       32'(bus.ack),       32'd0);
    chk("arst.burst_cnt", 32'(bus.burst_cnt), 32'd0);
    chk("arst.wdata",     32'(bus.wdata),     32'd0);
    bus.req = 4'b1001;
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    model_reset();
    apply(4'b1001, dw, 1'b0, 4'd0,    1'b0, 8'h00, 4'd0,    4'd0, "arst_rel");
    apply(4'b1001, dw, 1'b0, 4'b0001, 1'b1, 8'hA5, 4'b0001, 4'd0, "arst_first");

    // --- random traffic against the behavioural model -----------------------
    do_reset();
    rq = 4'd0;
    for (int i = 0; i < 4; i++) seq[i] = 6'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (rq[i]) rq[i] = ($urandom_range(0, 7) != 0);
        else       rq[i] = ($urandom_range(0, 2) == 0);
      end
      wf = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) rd[i*8 +: 8] = {2'(i), seq[i]};

      // expected outputs for this cycle from the model's ownership state
      eg = 4'd0; ew = 1'b0; ed = 8'h00; ea = 4'd0; eb = 4'd0;
      if (m_owner >= 0) begin
        eg = 4'(1 << m_owner);
        ew = rq[m_owner] && !wf;
        ed = rd[m_owner*8 +: 8];
        ea = ew ? eg : 4'd0;
        eb = 4'(m_cnt);
      end
      apply(rq, rd, wf, eg, ew, ed, ea, eb, "rand");

      // model advance at the rising edge
      if (m_owner < 0) begin
        if (rq != 4'd0) begin
          pick = -1;
          for (int k = 1; k <= 4; k++) begin
            if (pick < 0 && rq[(m_last + k) % 4]) pick = (m_last + k) % 4;
          end
          m_owner = pick;
          m_last  = pick;
          m_cnt   = 0;
        end
      end else begin
        if (ew) begin
          seq[m_owner] = seq[m_owner] + 6'd1;  // requester presents next word
          m_cnt++;
        end
        if (!rq[m_owner] || m_cnt == MAX_BURST) begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
